// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory responder.
// No ports: provides the FSM state type, data/byte-enable widths,
// wait-counter width and the response error codes.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 4;  // holds WAIT_CYCLES-1 for WAIT_CYCLES up to 15

  localparam logic ERR_NONE   = 1'b0;
  localparam logic ERR_ACCESS = 1'b1;  // misaligned or out-of-range access

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_resp_if.sv
// MEM-stage data port: valid/ready request channel and valid/ready
// response channel.
//   master : requester (MEM stage) - drives req_*_i and rsp_ready_i
//   slave  : responder (dmem_resp) - drives req_ready_o and rsp_*_o
interface dmem_resp_if;
  import dmem_pkg::*;

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [31:0]       req_addr_i;
  logic [WORD_W-1:0] req_wdata_i;
  logic [BE_W-1:0]   req_be_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [WORD_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface

// File: rtl/dmem_ram_bank.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32, byte-writable.
//   clk   : clock
//   en    : access enable; read data registered on the enabled edge
//   we    : 1 = write the bytes selected by be
//   be    : byte enables, bit k covers wdata[8k+7:8k]
//   idx   : word index
//   wdata : write data
//   rdata : registered read data (old contents on a write edge)
// Contents are not reset.
module dmem_ram_bank
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned k = 0; k < BE_W; k++) begin
          if (be[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder serving MEM-stage loads/stores with WAIT_CYCLES
// wait states, one outstanding request, and error flagging for
// misaligned or out-of-range addresses (no address wrap).
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : dmem_resp_if.slave - request/response handshake channels
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  dmem_resp_if.slave  bus
);

  localparam int unsigned      IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_err;
  logic              r_rd_sel;

  logic              w_acc;
  logic              w_req_ready;
  logic              w_rsp_valid;
  logic              w_we;
  logic [31:0]       w_addr;
  logic [WORD_W-1:0] w_wdata;
  logic [BE_W-1:0]   w_be;
  logic              w_err;
  logic              w_ram_en;
  logic [WORD_W-1:0] w_ram_rdata;

  // With zero wait states the access happens at the accept edge, so the
  // access operands come straight from the bus while idle.
  assign w_we    = (r_state == ST_IDLE) ? bus.req_we_i    : r_we;
  assign w_addr  = (r_state == ST_IDLE) ? bus.req_addr_i  : r_addr;
  assign w_wdata = (r_state == ST_IDLE) ? bus.req_wdata_i : r_wdata;
  assign w_be    = (r_state == ST_IDLE) ? bus.req_be_i    : r_be;

  // Full-width compare: high address bits are never dropped.
  assign w_err    = (w_addr[1:0] != 2'b00) || (w_addr[31:2] >= 30'(DEPTH_WORDS));
  assign w_ram_en = w_acc && !w_err && !rst;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_acc       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid_i) begin
          if (WAIT_CYCLES == 0) begin
            w_acc  = 1'b1;
            w_next = ST_RESP;
          end else begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_acc  = 1'b1;
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready_i) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_err    <= ERR_NONE;
      r_rd_sel <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && bus.req_valid_i) begin
        r_we    <= bus.req_we_i;
        r_addr  <= bus.req_addr_i;
        r_wdata <= bus.req_wdata_i;
        r_be    <= bus.req_be_i;
        r_cnt   <= CNT_INIT;
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_acc) begin
        r_err    <= w_err ? ERR_ACCESS : ERR_NONE;
        r_rd_sel <= !w_we && !w_err;
      end
    end
  end

  dmem_ram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .en    (w_ram_en),
    .we    (w_we),
    .be    (w_be),
    .idx   (w_addr[IDX_W+1:2]),
    .wdata (w_wdata),
    .rdata (w_ram_rdata)
  );

  // The RAM's output register is only loaded at the access edge, so it
  // holds steady through RESP and can be muxed out directly instead of
  // being copied into another register (which would add a cycle).
  assign bus.req_ready_o = w_req_ready;
  assign bus.rsp_valid_o = w_rsp_valid;
  assign bus.rsp_rdata_o = (r_state == ST_RESP && r_rd_sel) ? w_ram_rdata : '0;
  assign bus.rsp_err_o   = (r_state == ST_RESP) && r_err;

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1;
  logic rst3;

  dmem_resp_if if1 ();
  dmem_resp_if if3 ();

  dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut1 (
    .clk (clk), .rst (rst1), .bus (if1.slave)
  );

  dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut3 (
    .clk (clk), .rst (rst3), .bus (if3.slave)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic f_ready(input bit s);
    return s ? if3.req_ready_o : if1.req_ready_o;
  endfunction
  function automatic logic f_valid(input bit s);
    return s ? if3.rsp_valid_o : if1.rsp_valid_o;
  endfunction
  function automatic logic [31:0] f_rdata(input bit s);
    return s ? if3.rsp_rdata_o : if1.rsp_rdata_o;
  endfunction
  function automatic logic f_err(input bit s);
    return s ? if3.rsp_err_o : if1.rsp_err_o;
  endfunction

  task automatic drive_req(input bit s, input logic v, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be);
    if (s) begin
      if3.req_valid_i = v; if3.req_we_i = we; if3.req_addr_i = addr;
      if3.req_wdata_i = wdata; if3.req_be_i = be;
    end else begin
      if1.req_valid_i = v; if1.req_we_i = we; if1.req_addr_i = addr;
      if1.req_wdata_i = wdata; if1.req_be_i = be;
    end
  endtask

  task automatic set_rsp_ready(input bit s, input logic v);
    if (s) if3.rsp_ready_i = v;
    else   if1.rsp_ready_i = v;
  endtask

  task automatic check_idle(input bit s, input string tag);
    check({tag, "/req_ready"}, 32'(f_ready(s)), 32'd1);
    check({tag, "/rsp_valid"}, 32'(f_valid(s)), 32'd0);
    check({tag, "/rsp_rdata"}, f_rdata(s), 32'd0);
    check({tag, "/rsp_err"},   32'(f_err(s)), 32'd0);
  endtask

  // Push the expectation, present the request for one accept edge, then
  // count edges until rsp_valid_o shows up (bounded).
  task automatic start_txn(input bit s, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input int exp_lat, input string tag);
    exp_t e;
    int   lat;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    check({tag, "/req_ready"}, 32'(f_ready(s)), 32'd1);
    drive_req(s, 1'b1, we, addr, wdata, be);
    @(posedge clk); #1;
    drive_req(s, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    lat = 1;
    while (f_valid(s) !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic finish_txn(input bit s, input string tag);
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
    end else begin
      e.rdata = 'x;
      e.err   = 1'bx;
    end
    check({tag, "/rsp_valid"}, 32'(f_valid(s)), 32'd1);
    check({tag, "/rdata"},     f_rdata(s), e.rdata);
    check({tag, "/err"},       32'(f_err(s)), 32'(e.err));
    set_rsp_ready(s, 1'b1);
    @(posedge clk); #1;
    set_rsp_ready(s, 1'b0);
    check({tag, "/valid_clr"}, 32'(f_valid(s)), 32'd0);
    check({tag, "/idle_rdy"},  32'(f_ready(s)), 32'd1);
  endtask

  task automatic txn(input bit s, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input int exp_lat, input string tag);
    start_txn(s, we, addr, wdata, be, exp_rdata, exp_err, exp_lat, tag);
    finish_txn(s, tag);
  endtask

  initial begin
    rst1 = 1'b1;
    rst3 = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_rsp_ready(1'b0, 1'b0);
    set_rsp_ready(1'b1, 1'b0);
    @(posedge clk); #1;
    rst1 = 1'b0;
    rst3 = 1'b0;
    check_idle(1'b0, "reset1");
    check_idle(1'b1, "reset3");

    // WAIT_CYCLES=1: store/load, byte strobes
    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 2, "st10");
    txn(1'b0, 1'b0, 32'h10, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 2, "ld10");
    txn(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 32'h0,     1'b0, 2, "st10_be");
    txn(1'b0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDE22BE44, 1'b0, 2, "ld10_be");

    // Errors: misaligned, out of range, high bits set; none may write
    txn(1'b0, 1'b0, 32'h13,       32'h0,        4'hF, 32'h0, 1'b1, 2, "ld_misal");
    txn(1'b0, 1'b1, 32'h0,        32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 2, "st0");
    txn(1'b0, 1'b1, 32'h1000,     32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 2, "st_oor");
    txn(1'b0, 1'b1, 32'h2,        32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 2, "st_misal");
    txn(1'b0, 1'b1, 32'h80000010, 32'h0,        4'hF, 32'h0, 1'b1, 2, "st_hi");
    txn(1'b0, 1'b0, 32'h1000,     32'h0,        4'hF, 32'h0, 1'b1, 2, "ld_oor");
    txn(1'b0, 1'b0, 32'h0,  32'h0, 4'hF, 32'hA5A5A5A5, 1'b0, 2, "ld0_nowrap");
    txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDE22BE44, 1'b0, 2, "ld10_nohi");

    // Last valid word and be=0 no-op store
    txn(1'b0, 1'b1, 32'hFFC, 32'h5A5A0FF0, 4'hF, 32'h0,        1'b0, 2, "st_last");
    txn(1'b0, 1'b0, 32'hFFC, 32'h0,        4'hF, 32'h5A5A0FF0, 1'b0, 2, "ld_last");
    txn(1'b0, 1'b1, 32'h4,   32'h01020304, 4'hF, 32'h0,        1'b0, 2, "st4");
    txn(1'b0, 1'b1, 32'h4,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 2, "st4_be0");
    txn(1'b0, 1'b0, 32'h4,   32'h0,        4'hF, 32'h01020304, 1'b0, 2, "ld4");

    // Backpressure with the next request already waiting on the bus
    start_txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDE22BE44, 1'b0, 2, "bp");
    drive_req(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    for (int i = 0; i < 5; i++) begin
      check("bp/hold_valid", 32'(f_valid(1'b0)), 32'd1);
      check("bp/hold_rdata", f_rdata(1'b0), 32'hDE22BE44);
      check("bp/hold_ready", 32'(f_ready(1'b0)), 32'd0);
      @(posedge clk); #1;
    end
    finish_txn(1'b0, "bp");
    txn(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 32'hA5A5A5A5, 1'b0, 2, "after_bp");

    // WAIT_CYCLES=3: reset on the would-be access edge aborts the store
    txn(1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0, 1'b0, 4, "st20");
    drive_req(1'b1, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort/in_wait_ready", 32'(f_ready(1'b1)), 32'd0);
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    check_idle(1'b1, "abort");
    for (int i = 0; i < 4; i++) begin
      check("abort/no_rsp", 32'(f_valid(1'b1)), 32'd0);
      @(posedge clk); #1;
    end
    txn(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 32'h12345678, 1'b0, 4, "ld20");

    // Reset in RESP drops the response but keeps the committed store
    start_txn(1'b1, 1'b1, 32'h24, 32'h0BADC0DE, 4'hF, 32'h0, 1'b0, 4, "st24");
    check("st24/rsp_valid", 32'(f_valid(1'b1)), 32'd1);
    void'(sb.pop_front());
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    check_idle(1'b1, "resp_rst");
    txn(1'b1, 1'b0, 32'h24, 32'h0, 4'hF, 32'h0BADC0DE, 1'b0, 4, "ld24");

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
